// File: rtl/seg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder_if
//   Groups the read-back display buses and the recovered display status.
//   master : the side driving the display buses (counter path / testbench)
//   slave  : the decoder, which observes the buses and reports status
//
//   enable      [3:0]  digit enables, active-low, bit i selects digit i
//   sevenseg    [7:0]  segments, active-low, bit7=a .. bit1=g, bit0=dp
//   digits      [15:0] recovered BCD, digit i in [4i+3:4i]
//   digit_valid [3:0]  digit i holds a legal, non-stale accepted value
//   dp          [3:0]  decimal point of digit i, active-high
//   err         [3:0]  last accepted pattern of digit i was not a digit
//   stale       [3:0]  digit i has not been accepted for TIMEOUT cycles
//   frame_valid        one-cycle pulse once all four digits were refreshed
// ---------------------------------------------------------------------------
interface seg_scan_decoder_if;
  logic [3:0]  enable;
  logic [7:0]  sevenseg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  dp;
  logic [3:0]  err;
  logic [3:0]  stale;
  logic        frame_valid;

  modport master (
    output enable, sevenseg,
    input  digits, digit_valid, dp, err, stale, frame_valid
  );

  modport slave (
    input  enable, sevenseg,
    output digits, digit_valid, dp, err, stale, frame_valid
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
//   Monitors the active-low seven-segment and digit-enable buses and recovers
//   the BCD value, decimal point, error and staleness status of 4 digits.
//   Works for multiplexed scanning (one enable low) and static drive (all
//   enables low). A pattern is accepted once it has been seen unchanged for
//   STABLE_CYCLES synchronized samples; it is accepted only once per run.
//
//   Ports:
//     clock    rising-edge system clock
//     reset_n  asynchronous active-low reset
//     bus      seg_scan_decoder_if.slave (display buses in, status out)
//
//   Parameters:
//     STABLE_CYCLES  identical samples needed before acceptance (>= 2)
//     TIMEOUT        cycles without acceptance before a digit goes stale
// ---------------------------------------------------------------------------
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 100000000
) (
  input  logic              clock,
  input  logic              reset_n,
  seg_scan_decoder_if.slave bus
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  // Bus-idle level (all enables and segments off). The sample registers
  // reset to it so the cleared pipeline never looks like a lit display.
  localparam logic [11:0] BUS_IDLE = 12'hFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED} state_t;

  state_t           state_reg;
  logic [11:0]      sync1_reg;
  logic [11:0]      sync2_reg;   // synchronized sample S = {enable, sevenseg}
  logic [11:0]      prev_reg;    // S from the previous cycle
  logic [RUN_W-1:0] run_reg;
  logic [3:0]       mask_reg;
  logic [3:0]       mask_next;
  logic             frame_reg;

  logic             sample_same;
  logic             all_off;
  logic             accept;
  logic             seg_legal;
  logic [3:0]       seg_value;

  assign sample_same = (sync2_reg == prev_reg);
  assign all_off     = (sync2_reg[11:8] == 4'hF);
  // Acceptance fires on the edge where the run counter reaches STABLE_CYCLES.
  assign accept      = (state_reg == ST_TRACK) && sample_same && !all_off &&
                       (run_reg >= RUN_LAST);

  // Segment decode of a..g (active-low); anything else is illegal.
  always_comb begin
    seg_legal = 1'b1;
    seg_value = 4'h0;
    case (sync2_reg[7:1])
      7'b0000001: seg_value = 4'd0;
      7'b1001111: seg_value = 4'd1;
      7'b0010010: seg_value = 4'd2;
      7'b0000110: seg_value = 4'd3;
      7'b1001100: seg_value = 4'd4;
      7'b0100100: seg_value = 4'd5;
      7'b0100000: seg_value = 4'd6;
      7'b0001111: seg_value = 4'd7;
      7'b0000000: seg_value = 4'd8;
      7'b0001100: seg_value = 4'd9;
      default: begin
        seg_legal = 1'b0;
        seg_value = 4'hF;
      end
    endcase
  end

  // Synchronizer, run counter and acceptance FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= BUS_IDLE;
      sync2_reg <= BUS_IDLE;
      prev_reg  <= BUS_IDLE;
      run_reg   <= '0;
      state_reg <= ST_IDLE;
    end else begin
      sync1_reg <= {bus.enable, bus.sevenseg};
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;

      if (!sample_same) begin
        run_reg <= RUN_ONE;
      end else if (run_reg != RUN_MAX) begin
        run_reg <= run_reg + RUN_ONE;
      end

      case (state_reg)
        ST_IDLE: begin
          if (!all_off) state_reg <= ST_TRACK;
        end
        ST_TRACK: begin
          if (all_off)     state_reg <= ST_IDLE;
          else if (accept) state_reg <= ST_LOCKED;
        end
        ST_LOCKED: begin
          // A locked pattern is never re-accepted; any change re-tracks.
          if (!sample_same) state_reg <= all_off ? ST_IDLE : ST_TRACK;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Per-digit result registers and timeout counters.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [3:0]       digit_reg;
    logic             valid_reg;
    logic             dp_reg;
    logic             err_reg;
    logic             stale_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic             digit_acc;
    logic             digit_expire;

    assign digit_acc    = accept && !sync2_reg[8 + gi];
    // Expiry fires once, on the edge the counter reaches TIMEOUT; an
    // acceptance on the same edge takes priority.
    assign digit_expire = !digit_acc && (tmo_reg == TMO_LAST);
    assign mask_next[gi] = digit_acc ? seg_legal :
                           (digit_expire ? 1'b0 : mask_reg[gi]);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        digit_reg <= 4'h0;
        valid_reg <= 1'b0;
        dp_reg    <= 1'b0;
        err_reg   <= 1'b0;
        stale_reg <= 1'b0;
        tmo_reg   <= '0;
      end else if (digit_acc) begin
        digit_reg <= seg_value;
        valid_reg <= seg_legal;
        err_reg   <= !seg_legal;
        dp_reg    <= !sync2_reg[0];
        stale_reg <= 1'b0;
        tmo_reg   <= '0;
      end else begin
        if (tmo_reg != TMO_MAX) tmo_reg <= tmo_reg + TMO_ONE;
        if (digit_expire) begin
          stale_reg <= 1'b1;
          valid_reg <= 1'b0;
        end
      end
    end

    assign bus.digits[4*gi +: 4] = digit_reg;
    assign bus.digit_valid[gi]   = valid_reg;
    assign bus.dp[gi]            = dp_reg;
    assign bus.err[gi]           = err_reg;
    assign bus.stale[gi]         = stale_reg;
  end

  // Frame tracking: the pulse and the mask clear happen on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg  <= 4'h0;
      frame_reg <= 1'b0;
    end else begin
      frame_reg <= (mask_next == 4'hF);
      mask_reg  <= (mask_next == 4'hF) ? 4'h0 : mask_next;
    end
  end

  assign bus.frame_valid = frame_reg;

endmodule
